// File: rtl/calc_sequencer.sv
// Streams (a, b) operand pairs through a single-shot arithmetic core.
// The core can only restart through reset, so each computation is framed by a release and a re-reset.
module calc_sequencer #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = WIDTH + 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  output logic [WIDTH-1:0]    core_a,
  output logic [WIDTH-1:0]    core_b,
  output logic                core_rst_n,
  input  logic [OP_WIDTH-1:0] core_out,
  input  logic                core_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OP_WIDTH-1:0] res_data,
  output logic                err,
  output logic [15:0]         done_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t              state_r;
  logic [WIDTH-1:0]    op_a_r;
  logic [WIDTH-1:0]    op_b_r;
  logic                op_full_r;
  logic [WD_W-1:0]     wd_r;
  logic [WIDTH-1:0]    core_a_r;
  logic [WIDTH-1:0]    core_b_r;
  logic                core_rst_n_r;
  logic                res_valid_r;
  logic [OP_WIDTH-1:0] res_data_r;
  logic                err_r;
  logic [15:0]         done_cnt_r;

  logic accept_s;
  logic consume_s;
  logic capture_s;

  assign accept_s  = in_valid && !op_full_r;
  assign consume_s = res_valid_r && res_ready;
  // A finished core may only hand over its result if the result register is free this edge.
  assign capture_s = (state_r == RUN) && core_ready && (!res_valid_r || res_ready);

  assign in_ready   = !op_full_r;
  assign core_a     = core_a_r;
  assign core_b     = core_b_r;
  assign core_rst_n = core_rst_n_r;
  assign res_valid  = res_valid_r;
  assign res_data   = res_data_r;
  assign err        = err_r;
  assign done_cnt   = done_cnt_r;

  // Operand slot, sequencing FSM, watchdog and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      op_a_r       <= '0;
      op_b_r       <= '0;
      op_full_r    <= 1'b0;
      wd_r         <= '0;
      core_a_r     <= '0;
      core_b_r     <= '0;
      core_rst_n_r <= 1'b0;
      res_valid_r  <= 1'b0;
      res_data_r   <= '0;
      err_r        <= 1'b0;
      done_cnt_r   <= 16'd0;
    end else begin
      if (accept_s) begin
        op_a_r    <= in_a;
        op_b_r    <= in_b;
        op_full_r <= 1'b1;
      end else if (state_r == IDLE) begin
        op_full_r <= 1'b0;
      end

      if (consume_s) begin
        res_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          core_rst_n_r <= 1'b0;
          if (op_full_r) begin
            core_a_r     <= op_a_r;
            core_b_r     <= op_b_r;
            core_rst_n_r <= 1'b1;
            wd_r         <= '0;
            state_r      <= RUN;
          end
        end
        RUN: begin
          if (capture_s) begin
            res_data_r   <= core_out;
            res_valid_r  <= 1'b1;
            done_cnt_r   <= done_cnt_r + 16'd1;
            core_rst_n_r <= 1'b0;
            state_r      <= IDLE;
          end else if (core_ready) begin
            // Result is ready but blocked downstream: a stall, not a hang.
            wd_r <= wd_r;
          end else if (wd_r == WD_LAST) begin
            err_r        <= 1'b1;
            core_rst_n_r <= 1'b0;
            state_r      <= IDLE;
          end else begin
            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          core_rst_n_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural core stub and a result scoreboard.
module tb_calc_sequencer;
  localparam int W   = 32;
  localparam int OPW = 36;
  localparam int TO  = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic           core_rst_n;
  logic [OPW-1:0] core_out;
  logic           core_ready;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [OPW-1:0] res_data;
  logic           err;
  logic [15:0]    done_cnt;
  logic           hang = 1'b0;
  logic [3:0]     core_cnt;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [OPW-1:0] exp_q[$];
  int             rise_q[$];
  int             consumed = 0;
  logic [15:0]    base = 16'd0;
  logic           exp_err = 1'b0;

  calc_sequencer #(.WIDTH(W), .OP_WIDTH(OPW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .core_a(core_a), .core_b(core_b),
    .core_rst_n(core_rst_n), .core_out(core_out), .core_ready(core_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Core stub: ready 10 edges after release, sticky until reset; never ready while hang is set.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      core_cnt   <= 4'd0;
      core_ready <= 1'b0;
    end else begin
      if (core_cnt != 4'd10) core_cnt <= core_cnt + 4'd1;
      if (core_cnt == 4'd9 && !hang) core_ready <= 1'b1;
    end
  end
  assign core_out = ((OPW'(core_a >> 1) + OPW'(core_b)) << 3) + ((OPW'(core_a) - OPW'(core_b >> 1)) << 2);

  function automatic logic [OPW-1:0] model(input longint a, input longint b);
    longint r;
    r = (a / 2 + b) * 8 + (a - b / 2) * 4;
    return r[OPW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) tick();
    check("send_ready", in_ready, 1);
    tick();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    for (int i = 0; i < 40 && !res_valid; i++) tick();
    check(name, res_valid, 1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    consumed = 0;
    base = 16'd0;
    exp_err = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_core_a", core_a, 0);
    check("rst_core_b", core_b, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_err", err, 0);
    check("rst_done_cnt", done_cnt, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Scoreboard and per-cycle invariants, sampled mid-cycle.
  initial begin
    logic           prev_hold = 1'b0;
    logic           prev_run = 1'b0;
    logic           prev_valid = 1'b0;
    logic [OPW-1:0] prev_data = '0;
    logic [W-1:0]   prev_a = '0;
    logic [W-1:0]   prev_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        prev_run = 1'b0;
        prev_valid = 1'b0;
      end else begin
        check("err", err, exp_err);
        check("done_cnt", done_cnt, 16'(base + 16'(consumed) + {15'd0, res_valid}));
        if (res_valid && !prev_valid) rise_q.push_back(cyc);
        if (prev_hold) check("res_hold", res_data, prev_data);
        if (prev_run && core_rst_n) begin
          check("core_a_stable", core_a, prev_a);
          check("core_b_stable", core_b, prev_b);
        end
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) check("res_unexpected", 1, 0);
          else check("res_data", res_data, exp_q.pop_front());
          consumed++;
        end
        if (in_valid && in_ready && !hang) exp_q.push_back(model(in_a, in_b));
        prev_hold = res_valid && !res_ready;
        prev_run = core_rst_n;
        prev_valid = res_valid;
        prev_data = res_data;
        prev_a = core_a;
        prev_b = core_b;
      end
    end
  end

  initial begin
    check("model_8_4", model(8, 4), 88);
    check("model_10_6", model(10, 6), 116);
    check("model_0_0", model(0, 0), 0);
    check("model_6_2", model(6, 2), 60);
    check("model_2_2", model(2, 2), 28);

    // Power-on reset
    #2 rst_n = 1'b0;
    clear_model();
    #1 check_reset_values();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    res_ready = 1'b1;

    // Single result with exact latency
    send(32'd8, 32'd4, 1'b0);
    check("single_core_held", core_rst_n, 0);
    tick();
    check("single_release", core_rst_n, 1);
    check("single_core_a", core_a, 8);
    check("single_core_b", core_b, 4);
    repeat (10) tick();
    check("single_not_early", res_valid, 0);
    tick();
    check("single_valid", res_valid, 1);
    check("single_data", res_data, 88);
    check("single_done_cnt", done_cnt, 1);
    check("single_err", err, 0);
    repeat (3) tick();

    // Back-to-back with in_valid held high
    rise_q.delete();
    send(32'd10, 32'd6, 1'b1);
    send(32'd0, 32'd0, 1'b1);
    send(32'd6, 32'd2, 1'b0);
    for (int i = 0; i < 60 && rise_q.size() < 3; i++) tick();
    check("b2b_count", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check("b2b_gap1", rise_q[1] - rise_q[0], 12);
      check("b2b_gap2", rise_q[2] - rise_q[1], 12);
    end
    repeat (3) tick();

    // Backpressure: two operations, consumer stalled
    res_ready = 1'b0;
    send(32'd10, 32'd6, 1'b0);
    send(32'd6, 32'd2, 1'b0);
    repeat (100) tick();
    check("bp_err", err, 0);
    check("bp_stalled_run", core_rst_n, 1);
    check("bp_core_ready", core_ready, 1);
    check("bp_valid", res_valid, 1);
    check("bp_first", res_data, 116);
    res_ready = 1'b1;
    tick();
    check("bp_second_valid", res_valid, 1);
    check("bp_second", res_data, 60);
    tick();
    check("bp_drained", res_valid, 0);
    repeat (2) tick();

    // Timeout with a core that never finishes
    hang = 1'b1;
    send(32'd5, 32'd5, 1'b0);
    repeat (TO) tick();
    check("to_not_early", err, 0);
    tick();
    check("to_err", err, 1);
    check("to_core_reset", core_rst_n, 0);
    exp_err = 1'b1;
    tick();
    check("to_no_result", res_valid, 0);
    hang = 1'b0;
    send(32'd8, 32'd4, 1'b0);
    wait_result("to_next_valid");
    check("to_next_data", res_data, 88);
    repeat (2) tick();

    // Reset in the middle of RUN
    send(32'd10, 32'd6, 1'b0);
    repeat (6) tick();
    check("mid_in_run", core_rst_n, 1);
    rst_n = 1'b0;
    clear_model();
    #1 check_reset_values();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(32'd8, 32'd4, 1'b0);
    wait_result("mid_after_valid");
    check("mid_after_data", res_data, 88);
    check("mid_after_cnt", done_cnt, 1);
    repeat (2) tick();

    // done_cnt wrap
    force dut.done_cnt_r = 16'hFFFF;
    #1 release dut.done_cnt_r;
    base = 16'hFFFF - 16'(consumed);
    tick();
    check("wrap_preload", done_cnt, 16'hFFFF);
    send(32'd2, 32'd2, 1'b0);
    wait_result("wrap_valid");
    check("wrap_data", res_data, 28);
    check("wrap_cnt", done_cnt, 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
